// File: rtl/jtkicker_romarb_pkg.sv
// Shared types for the Kicker ROM arbiter: requester indices, FSM states and
// the round-robin successor used among the video/PCM requesters.
package jtkicker_romarb_pkg;

    typedef enum logic [1:0] {
        MAIN = 2'd0,
        SCR  = 2'd1,
        OBJ  = 2'd2,
        PCM  = 2'd3
    } req_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    // Round-robin ring over the non-main requesters: scr -> obj -> pcm -> scr
    function automatic req_e rr_next(input req_e r);
        case (r)
            SCR:     return OBJ;
            OBJ:     return PCM;
            default: return SCR;
        endcase
    endfunction

endpackage

// File: rtl/jtkicker_romarb_slot.sv
// One-entry read cache for a single ROM requester: tag, data and valid bit,
// with optional byte extraction from the 32-bit SDRAM word pair at fill time.
module jtkicker_romarb_slot #(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter bit BYTE_SEL = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs_i,
    input  logic [AW-1:0] addr_i,
    input  logic          fill_i,
    input  logic [AW-1:0] fill_addr_i,
    input  logic [31:0]   fill_data_i,
    output logic          hit_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q;
    logic [AW-1:0] tag_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] fill_data;

    generate
        if (BYTE_SEL) begin : g_byte
            // Odd byte addresses live in the upper half of the 16-bit word
            logic unused_hi;
            assign unused_hi = &{1'b0, fill_data_i[31:16]};
            assign fill_data = fill_addr_i[0] ? fill_data_i[8 +: DW] : fill_data_i[0 +: DW];
        end else begin : g_word
            assign fill_data = fill_data_i[DW-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            tag_q   <= fill_addr_i;
            data_q  <= fill_data;
        end
    end

    assign hit_o  = cs_i & valid_q & (addr_i == tag_q);
    assign data_o = data_q;

endmodule

// File: rtl/jtkicker_romarb.sv
// Shares one SDRAM read port among main CPU, scroll, object and PCM ROM readers,
// each fronted by a one-entry cache. Main has priority but alternates under contention.
module jtkicker_romarb
    import jtkicker_romarb_pkg::*;
#(
    parameter logic [21:0] MAIN_START = 22'h00000,
    parameter logic [21:0] SCR_START  = 22'h10000,
    parameter logic [21:0] OBJ_START  = 22'h14000,
    parameter logic [21:0] PCM_START  = 22'h1C000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        main_cs,
    input  logic [15:0] main_addr,
    output logic        main_ok,
    output logic [7:0]  main_data,
    input  logic        scr_cs,
    input  logic [12:0] scr_addr,
    output logic        scr_ok,
    output logic [31:0] scr_data,
    input  logic        obj_cs,
    input  logic [13:0] obj_addr,
    output logic        obj_ok,
    output logic [31:0] obj_data,
    input  logic        pcm_cs,
    input  logic [15:0] pcm_addr,
    output logic        pcm_ok,
    output logic [7:0]  pcm_data,
    output logic        sdram_req,
    output logic [20:0] sdram_addr,
    input  logic        sdram_ack,
    input  logic        sdram_dok,
    input  logic [31:0] sdram_data,
    output logic [1:0]  dbg_state
);

    // Handshake: sdram_req/sdram_addr stay stable from issue until the cycle
    // sdram_ack is seen; sdram_dok is only honoured after (or with) that ack.

    state_e      st_q, st_d;
    req_e        gnt_q, gnt_d, rr_q, rr_d, arb;
    logic        last_main_q, last_main_d;
    logic        req_q, req_d;
    logic [20:0] addr_q, addr_d;
    logic [15:0] lat_q, lat_d;
    logic [3:0]  hit, pend;
    logic        fill;
    logic [20:0] req_waddr;
    logic [15:0] req_laddr;

    jtkicker_romarb_slot #(.AW(16), .DW(8), .BYTE_SEL(1'b1)) u_main (
        .clk(clk), .rst_n(rst_n), .cs_i(main_cs), .addr_i(main_addr),
        .fill_i(fill && gnt_q == MAIN), .fill_addr_i(lat_q), .fill_data_i(sdram_data),
        .hit_o(hit[MAIN]), .data_o(main_data)
    );

    jtkicker_romarb_slot #(.AW(13), .DW(32), .BYTE_SEL(1'b0)) u_scr (
        .clk(clk), .rst_n(rst_n), .cs_i(scr_cs), .addr_i(scr_addr),
        .fill_i(fill && gnt_q == SCR), .fill_addr_i(lat_q[12:0]), .fill_data_i(sdram_data),
        .hit_o(hit[SCR]), .data_o(scr_data)
    );

    jtkicker_romarb_slot #(.AW(14), .DW(32), .BYTE_SEL(1'b0)) u_obj (
        .clk(clk), .rst_n(rst_n), .cs_i(obj_cs), .addr_i(obj_addr),
        .fill_i(fill && gnt_q == OBJ), .fill_addr_i(lat_q[13:0]), .fill_data_i(sdram_data),
        .hit_o(hit[OBJ]), .data_o(obj_data)
    );

    jtkicker_romarb_slot #(.AW(16), .DW(8), .BYTE_SEL(1'b1)) u_pcm (
        .clk(clk), .rst_n(rst_n), .cs_i(pcm_cs), .addr_i(pcm_addr),
        .fill_i(fill && gnt_q == PCM), .fill_addr_i(lat_q), .fill_data_i(sdram_data),
        .hit_o(hit[PCM]), .data_o(pcm_data)
    );

    assign pend = {pcm_cs, obj_cs, scr_cs, main_cs} & ~hit;

    // Round-robin pick among scr/obj/pcm, then main overrides unless it won last time
    always_comb begin
        req_e cand;
        logic found;
        arb   = MAIN;
        found = 1'b0;
        cand  = rr_q;
        for (int i = 0; i < 3; i++) begin
            if (!found && pend[cand]) begin
                arb   = cand;
                found = 1'b1;
            end
            cand = rr_next(cand);
        end
        if (pend[MAIN] && !(last_main_q && |pend[3:1])) arb = MAIN;
    end

    always_comb begin
        req_waddr = '0;
        req_laddr = '0;
        case (arb)
            MAIN: begin
                req_waddr = MAIN_START[21:1] + {6'd0, main_addr[15:1]};
                req_laddr = main_addr;
            end
            SCR: begin
                req_waddr = SCR_START[21:1] + {8'd0, scr_addr};
                req_laddr = {3'd0, scr_addr};
            end
            OBJ: begin
                req_waddr = OBJ_START[21:1] + {7'd0, obj_addr};
                req_laddr = {2'd0, obj_addr};
            end
            default: begin
                req_waddr = PCM_START[21:1] + {6'd0, pcm_addr[15:1]};
                req_laddr = pcm_addr;
            end
        endcase
    end

    always_comb begin
        st_d        = st_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        last_main_d = last_main_q;
        req_d       = req_q;
        addr_d      = addr_q;
        lat_d       = lat_q;
        fill        = 1'b0;
        case (st_q)
            IDLE: begin
                if (|pend) begin
                    gnt_d       = arb;
                    lat_d       = req_laddr;
                    addr_d      = req_waddr;
                    req_d       = 1'b1;
                    st_d        = REQ;
                    last_main_d = (arb == MAIN);
                    if (arb != MAIN) rr_d = rr_next(arb);
                end
            end
            REQ: begin
                if (sdram_ack) begin
                    req_d = 1'b0;
                    if (sdram_dok) begin
                        fill = 1'b1;
                        st_d = IDLE;
                    end else begin
                        st_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (sdram_dok) begin
                    fill = 1'b1;
                    st_d = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= IDLE;
            gnt_q       <= MAIN;
            rr_q        <= SCR;
            last_main_q <= 1'b0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            lat_q       <= '0;
        end else begin
            st_q        <= st_d;
            gnt_q       <= gnt_d;
            rr_q        <= rr_d;
            last_main_q <= last_main_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            lat_q       <= lat_d;
        end
    end

    assign main_ok    = hit[MAIN];
    assign scr_ok     = hit[SCR];
    assign obj_ok     = hit[OBJ];
    assign pcm_ok     = hit[PCM];
    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;
    assign dbg_state  = st_q;

endmodule

// File: tb/tb_jtkicker_romarb.sv
// Directed and randomized checks of the ROM arbiter against a byte-addressed SDRAM image model.
module tb_jtkicker_romarb;
  import jtkicker_romarb_pkg::*;

  localparam logic [21:0] MAIN_S = 22'h00000;
  localparam logic [21:0] SCR_S  = 22'h10000;
  localparam logic [21:0] OBJ_S  = 22'h14000;
  localparam logic [21:0] PCM_S  = 22'h1C000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        main_cs, scr_cs, obj_cs, pcm_cs;
  logic [15:0] main_addr, pcm_addr;
  logic [12:0] scr_addr;
  logic [13:0] obj_addr;
  logic        main_ok, scr_ok, obj_ok, pcm_ok;
  logic [7:0]  main_data, pcm_data;
  logic [31:0] scr_data, obj_data;
  logic        sdram_req, sdram_ack, sdram_dok;
  logic [20:0] sdram_addr;
  logic [31:0] sdram_data;
  logic [1:0]  dbg_state;

  logic        auto_resp = 1'b0;
  logic        m_ack = 1'b0, m_dok = 1'b0, r_ack = 1'b0, r_dok = 1'b0;
  logic [31:0] m_data = '0, r_data = '0;
  int          n_req = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  assign sdram_ack  = auto_resp ? r_ack  : m_ack;
  assign sdram_dok  = auto_resp ? r_dok  : m_dok;
  assign sdram_data = auto_resp ? r_data : m_data;

  jtkicker_romarb dut (
    .clk(clk), .rst_n(rst_n),
    .main_cs(main_cs), .main_addr(main_addr), .main_ok(main_ok), .main_data(main_data),
    .scr_cs(scr_cs), .scr_addr(scr_addr), .scr_ok(scr_ok), .scr_data(scr_data),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_ok(obj_ok), .obj_data(obj_data),
    .pcm_cs(pcm_cs), .pcm_addr(pcm_addr), .pcm_ok(pcm_ok), .pcm_data(pcm_data),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .sdram_dok(sdram_dok), .sdram_data(sdram_data), .dbg_state(dbg_state)
  );

  // ---------------- reference model: SDRAM image ----------------
  function automatic logic [15:0] word16(input logic [20:0] w);
    logic [31:0] t;
    t = {11'd0, w} * 32'd40503;
    return t[23:8] ^ 16'h5A5A;
  endfunction

  function automatic logic [31:0] mem32(input logic [20:0] w);
    return {word16(w + 21'd1), word16(w)};
  endfunction

  // Little-endian byte at byte offset a inside a ROM region
  function automatic logic [7:0] exp_byte(input logic [21:0] start, input logic [15:0] a);
    logic [21:0] b;
    logic [15:0] w;
    b = start + {6'd0, a};
    w = word16(b[21:1]);
    return b[0] ? w[15:8] : w[7:0];
  endfunction

  // Two consecutive 16-bit words at word offset a inside a ROM region
  function automatic logic [31:0] exp_words(input logic [21:0] start, input logic [13:0] a);
    logic [21:0] b;
    b = start + {7'd0, a, 1'b0};
    return {word16(b[21:1] + 21'd1), word16(b[21:1])};
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- SDRAM responder (random latency) ----------------
  int          resp_st = 0, ack_cnt = 0, dok_cnt = 0;
  logic [20:0] r_addr = '0;
  always @(negedge clk) begin
    r_ack  = 1'b0;
    r_dok  = 1'b0;
    r_data = $urandom;
    if (!auto_resp || !rst_n) begin
      resp_st = 0;
    end else begin
      if (resp_st == 0 && sdram_req) begin
        ack_cnt = $urandom_range(0, 2);
        resp_st = 1;
      end
      if (resp_st == 1) begin
        if (ack_cnt == 0) begin
          r_ack   = 1'b1;
          r_addr  = sdram_addr;
          n_req++;
          dok_cnt = $urandom_range(0, 3);
          resp_st = 2;
        end else begin
          ack_cnt--;
        end
      end
      if (resp_st == 2 && !r_ack) begin
        if (dok_cnt == 0) begin
          r_dok   = 1'b1;
          r_data  = mem32(r_addr);
          resp_st = 0;
        end else begin
          dok_cnt--;
        end
      end else if (resp_st == 2 && dok_cnt == 0) begin
        r_dok   = 1'b1;
        r_data  = mem32(r_addr);
        resp_st = 0;
      end
    end
  end

  // ---------------- manual driver tasks ----------------
  task automatic wait_req(input string tag, input logic [20:0] exp_a);
    int n;
    n = 0;
    while (sdram_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, {31'd0, sdram_req}, 32'd1);
    chk({tag, "_addr"}, {11'd0, sdram_addr}, {11'd0, exp_a});
  endtask

  task automatic serve(input string tag, input logic [20:0] exp_a);
    wait_req(tag, exp_a);
    m_ack = 1'b1;
    @(negedge clk);
    m_ack  = 1'b0;
    m_dok  = 1'b1;
    m_data = mem32(exp_a);
    @(negedge clk);
    m_dok  = 1'b0;
    m_data = $urandom;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    main_cs = 0; scr_cs = 0; obj_cs = 0; pcm_cs = 0;
    main_addr = '0; scr_addr = '0; obj_addr = '0; pcm_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, sdram_req}, 32'd0);
    chk("rst_addr", {11'd0, sdram_addr}, 32'd0);
    chk("rst_oks", {28'd0, main_ok, scr_ok, obj_ok, pcm_ok}, 32'd0);
    chk("rst_data", {24'd0, main_data} | scr_data | obj_data | {24'd0, pcm_data}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // First main read, odd byte
    main_cs = 1; main_addr = 16'h0003;
    @(negedge clk);
    chk("t1_req", {31'd0, sdram_req}, 32'd1);
    chk("t1_addr", {11'd0, sdram_addr}, 32'h1);
    chk("t1_ok_pre", {31'd0, main_ok}, 32'd0);
    m_ack = 1;
    @(negedge clk);
    m_ack = 0;
    chk("t1_req_drop", {31'd0, sdram_req}, 32'd0);
    m_dok = 1; m_data = 32'hCDEF_AB12;
    @(negedge clk);
    m_dok = 0; m_data = $urandom;
    chk("t1_ok", {31'd0, main_ok}, 32'd1);
    chk("t1_data", {24'd0, main_data}, 32'hAB);

    // Repeat hits, then even byte of same word; stray dok in REQ, then ack+dok together
    repeat (2) begin
      @(negedge clk);
      chk("t2_hit_noreq", {31'd0, sdram_req}, 32'd0);
      chk("t2_hit_ok", {31'd0, main_ok}, 32'd1);
    end
    main_addr = 16'h0002;
    #1 chk("t2_miss_ok", {31'd0, main_ok}, 32'd0);
    @(negedge clk);
    chk("t2_req", {31'd0, sdram_req}, 32'd1);
    chk("t2_addr", {11'd0, sdram_addr}, 32'h1);
    m_dok = 1; m_data = 32'hFFFF_FFFF;
    @(negedge clk);
    m_dok = 0;
    chk("t2_stray_req", {31'd0, sdram_req}, 32'd1);
    chk("t2_stray_state", {30'd0, dbg_state}, 32'd1);
    chk("t2_stray_ok", {31'd0, main_ok}, 32'd0);
    m_ack = 1; m_dok = 1; m_data = 32'h5555_AB12;
    @(negedge clk);
    m_ack = 0; m_dok = 0;
    chk("t2_same_state", {30'd0, dbg_state}, 32'd0);
    chk("t2_ok", {31'd0, main_ok}, 32'd1);
    chk("t2_data", {24'd0, main_data}, 32'h12);
    chk("t2_req_low", {31'd0, sdram_req}, 32'd0);
    m_dok = 1; m_data = 32'h0000_9999;
    @(negedge clk);
    m_dok = 0;
    chk("t2_idle_dok_data", {24'd0, main_data}, 32'h12);
    chk("t2_idle_dok_state", {30'd0, dbg_state}, 32'd0);

    // scr/obj/pcm together, no main: round-robin from scr
    main_cs = 0;
    scr_cs = 1; scr_addr = 13'h0123;
    obj_cs = 1; obj_addr = 14'h2345;
    pcm_cs = 1; pcm_addr = 16'h4567;
    serve("t3_scr", 21'h08123);
    chk("t3_scr_ok", {31'd0, scr_ok}, 32'd1);
    chk("t3_scr_data", scr_data, exp_words(SCR_S, {1'b0, scr_addr}));
    serve("t3_obj", 21'h0A000 + 21'h2345);
    chk("t3_obj_ok", {31'd0, obj_ok}, 32'd1);
    chk("t3_obj_data", obj_data, exp_words(OBJ_S, obj_addr));
    serve("t3_pcm", 21'h0E000 + 21'h22B3);
    chk("t3_pcm_ok", {31'd0, pcm_ok}, 32'd1);
    chk("t3_pcm_data", {24'd0, pcm_data}, {24'd0, exp_byte(PCM_S, 16'h4567)});

    // Main keeps missing while scr waits: main, scr, main
    main_cs = 1; main_addr = 16'h0100;
    scr_addr = 13'h0456;
    serve("t4_main1", 21'h00080);
    chk("t4_main1_data", {24'd0, main_data}, {24'd0, exp_byte(MAIN_S, 16'h0100)});
    main_addr = 16'h0201;
    serve("t4_scr", 21'h08456);
    chk("t4_scr_ok", {31'd0, scr_ok}, 32'd1);
    chk("t4_scr_data", scr_data, exp_words(SCR_S, 14'h0456));
    serve("t4_main2", 21'h00100);
    chk("t4_main2_ok", {31'd0, main_ok}, 32'd1);
    chk("t4_main2_data", {24'd0, main_data}, {24'd0, exp_byte(MAIN_S, 16'h0201)});

    // Scroll address changes while waiting for data
    main_cs = 0;
    scr_addr = 13'h0AAA;
    wait_req("t5_scr1", 21'h08AAA);
    m_ack = 1;
    @(negedge clk);
    m_ack = 0;
    scr_addr = 13'h0BBB;
    m_dok = 1; m_data = mem32(21'h08AAA);
    @(negedge clk);
    m_dok = 0;
    chk("t5_ok_stale", {31'd0, scr_ok}, 32'd0);
    serve("t5_scr2", 21'h08BBB);
    chk("t5_ok_new", {31'd0, scr_ok}, 32'd1);
    chk("t5_data_new", scr_data, exp_words(SCR_S, 14'h0BBB));
    scr_addr = 13'h0AAA;
    #1 chk("t5_old_evicted", {31'd0, scr_ok}, 32'd0);
    scr_cs = 0;

    // Object cs drops mid-transaction; fill still lands
    obj_addr = 14'h1111;
    wait_req("t6_obj", 21'h0B111);
    m_ack = 1;
    @(negedge clk);
    m_ack = 0;
    obj_cs = 0;
    m_dok = 1; m_data = mem32(21'h0B111);
    @(negedge clk);
    m_dok = 0;
    chk("t6_ok_cs0", {31'd0, obj_ok}, 32'd0);
    obj_cs = 1;
    #1 chk("t6_ok_back", {31'd0, obj_ok}, 32'd1);
    chk("t6_data", obj_data, exp_words(OBJ_S, 14'h1111));
    @(negedge clk);
    chk("t6_noreq", {31'd0, sdram_req}, 32'd0);

    // Reset during WAIT, then a stale dok
    pcm_addr = 16'h0010;
    wait_req("t7_pcm", 21'h0E008);
    m_ack = 1;
    @(negedge clk);
    m_ack = 0;
    chk("t7_in_wait", {30'd0, dbg_state}, 32'd2);
    rst_n = 0;
    #1;
    chk("t7_rst_state", {30'd0, dbg_state}, 32'd0);
    chk("t7_rst_req", {31'd0, sdram_req}, 32'd0);
    chk("t7_rst_oks", {28'd0, main_ok, scr_ok, obj_ok, pcm_ok}, 32'd0);
    main_cs = 0; scr_cs = 0; obj_cs = 0; pcm_cs = 0;
    @(negedge clk);
    rst_n = 1;
    m_dok = 1; m_data = mem32(21'h0E008);
    @(negedge clk);
    m_dok = 0;
    chk("t7_stale_state", {30'd0, dbg_state}, 32'd0);
    pcm_cs = 1;
    #1 chk("t7_stale_ok", {31'd0, pcm_ok}, 32'd0);
    chk("t7_stale_data", {24'd0, pcm_data}, 32'd0);
    pcm_cs = 0;

    // Randomized rounds against the cache/ROM model
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    auto_resp = 1;
    begin
      logic        mv[4];
      logic [15:0] mt[4];
      for (int k = 0; k < 4; k++) begin
        mv[k] = 1'b0;
        mt[k] = '0;
      end
      for (int r = 0; r < 40; r++) begin
        logic [3:0]  cs;
        logic [15:0] a[4];
        int          miss, base, cyc;
        logic        done;
        @(negedge clk);
        miss = 0;
        for (int k = 0; k < 4; k++) begin
          cs[k] = 1'($urandom_range(0, 1));
          a[k]  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 5));
        end
        a[1] = {3'd0, a[1][12:0]};
        a[2] = {2'd0, a[2][13:0]};
        for (int k = 0; k < 4; k++)
          if (cs[k] && !(mv[k] && mt[k] == a[k])) miss++;
        main_cs = cs[0]; main_addr = a[0];
        scr_cs  = cs[1]; scr_addr  = a[1][12:0];
        obj_cs  = cs[2]; obj_addr  = a[2][13:0];
        pcm_cs  = cs[3]; pcm_addr  = a[3];
        base = n_req;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 200) begin
          @(negedge clk);
          cyc++;
          done = ({pcm_ok, obj_ok, scr_ok, main_ok} == cs);
        end
        repeat (3) @(negedge clk);
        chk("rnd_done", {31'd0, done}, 32'd1);
        chk("rnd_oks", {28'd0, pcm_ok, obj_ok, scr_ok, main_ok}, {28'd0, cs});
        chk("rnd_nreq", n_req - base, miss);
        for (int k = 0; k < 4; k++)
          if (cs[k]) begin
            mv[k] = 1'b1;
            mt[k] = a[k];
          end
        if (mv[0]) chk("rnd_main_data", {24'd0, main_data}, {24'd0, exp_byte(MAIN_S, mt[0])});
        if (mv[1]) chk("rnd_scr_data", scr_data, exp_words(SCR_S, mt[1][13:0]));
        if (mv[2]) chk("rnd_obj_data", obj_data, exp_words(OBJ_S, mt[2][13:0]));
        if (mv[3]) chk("rnd_pcm_data", {24'd0, pcm_data}, {24'd0, exp_byte(PCM_S, mt[3])});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtkicker_romarb.md
Name: jtkicker_romarb

Overview:
- Shares one SDRAM read port between the four ROM requesters of the Kicker-family cores: main CPU, scroll tiles, object tiles and PCM samples.
- Sits between the game top level and the SDRAM controller.
- Each requester has a one-entry cache, so a repeated address returns `ok` with no SDRAM access.
- Main has priority, with anti-starvation alternation; video and PCM requesters are served round-robin.

Parameters:
- `MAIN_START`, 22'h00000, byte offset of main ROM in SDRAM
- `SCR_START`, 22'h10000, byte offset of scroll ROM
- `OBJ_START`, 22'h14000, byte offset of object ROM
- `PCM_START`, 22'h1C000, byte offset of PCM ROM

Ports:
- `clk`  in  1  system clock; the only clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `main_cs`  in  1  main read request
- `main_addr`  in  16  main byte address
- `main_ok`  out  1  `main_data` valid for current `main_addr`
- `main_data`  out  8  main read byte
- `scr_cs`  in  1  scroll read request
- `scr_addr`  in  13  scroll address, 16-bit word units
- `scr_ok`  out  1  `scr_data` valid
- `scr_data`  out  32  two consecutive words from `scr_addr`
- `obj_cs`  in  1  object read request
- `obj_addr`  in  14  object address, 16-bit word units
- `obj_ok`  out  1  `obj_data` valid
- `obj_data`  out  32  two consecutive words from `obj_addr`
- `pcm_cs`  in  1  PCM read request
- `pcm_addr`  in  16  PCM byte address
- `pcm_ok`  out  1  `pcm_data` valid
- `pcm_data`  out  8  PCM byte
- `sdram_req`  out  1  read request to SDRAM controller
- `sdram_addr`  out  21  SDRAM 16-bit word address (byte address bits [21:1])
- `sdram_ack`  in  1  request accepted, one cycle pulse
- `sdram_dok`  in  1  read data valid, one cycle pulse
- `sdram_data`  in  32  word at `sdram_addr` in [15:0], next word in [31:16]

Behaviour:
- Reset (`rst_n`=0, asynchronous):
  - all outputs 0; `sdram_addr`=0
  - cache valid bits cleared; round-robin pointer set to `scr`; `last_was_main`=0
  - FSM forced to `IDLE`
- Cache: per requester a tag (full requester address), a data register and a valid bit.
  - Hit = `cs` & valid & (addr == tag).
  - `ok` = hit, combinational from the registered tag/valid. `data` is always the registered cache data.
- Byte requesters (main, pcm):
  - Tag is the full byte address.
  - Cached byte is `sdram_data[7:0]` when addr[0]=0, otherwise `sdram_data[15:8]`, selected at fill time.
- Address map: word address = (START>>1) + word offset.
  - scr/obj: the word offset is the port address.
  - main/pcm: the word offset is addr[15:1].
  - 21-bit sum; overflow wraps silently.
- Pending (per requester) = `cs` & ~hit.
- FSM `IDLE`:
  - If any requester is pending, arbitrate, latch the grant index and the requester address, drive `sdram_addr`, assert `sdram_req` at the next edge, go to `REQ`.
  - Arbitration: main wins unless `last_was_main`=1 and a non-main requester is pending.
  - Among scr/obj/pcm: the first pending at or after the round-robin pointer wins; the pointer then moves to the one after the winner.
  - `last_was_main` is set on a main grant and cleared on any other grant.
- FSM `REQ`:
  - Hold `sdram_req` and `sdram_addr` stable until `sdram_ack`.
  - On `sdram_ack`, deassert `sdram_req` at that edge and go to `WAIT`.
- FSM `WAIT`:
  - On `sdram_dok`, write the granted cache: tag = latched address, data = `sdram_data` or its selected byte, valid=1.
  - Then go to `IDLE`.
- Latency: with a requester idle-pending at cycle N and `ack`/`dok` returned immediately, `sdram_req` is high from N+1, the fill happens at the `dok` edge, and `ok` is high the cycle after `dok`.
- One `IDLE` cycle separates consecutive transactions.
- Boundary conditions:
  - `cs` drops mid-transaction: the transaction completes and fills the cache; `ok` stays 0 while `cs`=0.
  - Address changes mid-transaction: the fill uses the latched address. The new address misses and issues a new request after `IDLE`.
  - `sdram_dok` in `IDLE` or `REQ`: ignored.
  - `sdram_ack` and `sdram_dok` in the same cycle while in `REQ`: treated as ack followed immediately by fill; next state `IDLE`.
  - Reset mid-transaction: immediate `IDLE`; a stale `dok` after reset is ignored.
  - Simultaneous pending on all four: main first, then scr/obj/pcm in round-robin order, with main alternating in between.

Decomposition:
- Shared package `jtkicker_romarb_pkg`:
  - requester index enum (`MAIN`, `SCR`, `OBJ`, `PCM`)
  - FSM state enum (`IDLE`, `REQ`, `WAIT`)
- Natural sub-module `jtkicker_romarb_slot`, instantiated four times, parameterised by address and data width. It holds the tag, data and valid registers and produces `hit`/`ok`, with a fill enable and a byte-select option.

Test Plan:
- Reset, then `main_cs`=1 with `main_addr`=16'h0003 -> `sdram_addr`=21'h00001 and `sdram_req`=1 on the next edge. `dok` with data 32'hxxxx_AB12 -> `main_data`=8'hAB and `main_ok`=1 the next cycle.
- Repeat `main_addr` 16'h0003 after the fill -> `main_ok`=1 immediately with no new `sdram_req`. Change to 16'h0002 -> miss, `sdram_req` for word 21'h00001 again, data byte [7:0].
- `scr_cs`, `obj_cs` and `pcm_cs` pending together with no main -> grants in order scr (21'h08000+addr), obj (21'h0A000+addr), pcm (21'h0E000+addr>>1).
- `main_cs` held on a changing address with `scr_cs` pending -> grants alternate main, scr, main; scr completes within 2 transactions.
- `scr_addr` changed while in `WAIT` -> the fill stores the old tag, `scr_ok` stays 0, and a second request is issued with the new address.
- `rst_n` pulsed low during `WAIT`, then `sdram_dok` pulsed -> all `ok`=0, no cache fill, FSM in `IDLE`.
